// File: rtl/uart_rx_core_pkg.sv
// uart_rx_core_pkg
// Shared types and constants for the 8N1 UART receiver: FSM state encoding,
// oversampling ratio, mid-bit sample point and frame data width.
package uart_rx_core_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned DATA_BITS  = 8;

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  typedef logic [TICK_W-1:0]    tick_t;
  typedef logic [BIT_W-1:0]     bit_idx_t;
  typedef logic [DATA_BITS-1:0] data_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    START,
    DATA,
    STOP,
    ERROR
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if
// Bundles the receiver's line-side inputs and byte-side outputs.
//   serial_in : serial line, idle high, asynchronous to CLK
//   x16_BAUD  : one-CLK enable pulse at 16x baud
//   Do        : last correctly received byte
//   valid     : one-CLK pulse when Do updates
//   error     : sticky framing error
// master : environment side (drives line and tick, observes results)
// slave  : receiver side
interface uart_rx_core_if;
  import uart_rx_core_pkg::*;

  logic  serial_in;
  logic  x16_BAUD;
  data_t Do;
  logic  valid;
  logic  error;

  modport master (
    output serial_in,
    output x16_BAUD,
    input  Do,
    input  valid,
    input  error
  );

  modport slave (
    input  serial_in,
    input  x16_BAUD,
    output Do,
    output valid,
    output error
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line. Resets to 1 so the
// receiver sees an idle (high) line while reset is asserted.
//   CLK      : system clock
//   reset    : asynchronous active-high reset
//   async_in : raw serial line
//   sync_out : line synchronized to CLK
module uart_rx_sync (
  input  logic CLK,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [1:0] ff_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ff_q <= '1;
    end else begin
      ff_q <= {ff_q[0], async_in};
    end
  end

  assign sync_out = ff_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
// 8N1 UART receiver, LSB first, oversampled by a 16x-baud tick. After reset it
// requires P_REG_MODE_TH consecutive high ticks before hunting start bits.
// Any framing fault (false start or low stop bit) latches error until reset.
//   CLK   : system clock, rising edge
//   reset : asynchronous active-high reset
//   rx_if : line input, tick enable, Do / valid / error outputs (slave side)
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned P_REG_MODE_TH = 160
) (
  input  logic           CLK,
  input  logic           reset,
  uart_rx_core_if.slave  rx_if
);

  localparam int unsigned IDLE_W = $clog2(P_REG_MODE_TH + 1);
  localparam logic [IDLE_W-1:0] IDLE_TH = IDLE_W'(P_REG_MODE_TH);

  rx_state_t         state_q, state_d;
  tick_t             tick_q, tick_d;
  bit_idx_t          bit_q, bit_d;
  data_t             shift_q, shift_d;
  data_t             do_q, do_d;
  logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
  logic              valid_q, valid_d;
  logic              rx;

  uart_rx_sync u_sync (
    .CLK      (CLK),
    .reset    (reset),
    .async_in (rx_if.serial_in),
    .sync_out (rx)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      do_q    <= '0;
      idle_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      do_q    <= do_d;
      idle_q  <= idle_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    do_d     = do_q;
    idle_d   = idle_q;
    // valid_d defaults low every CLK, so the strobe lasts one CLK even when
    // ticks are sparse.
    valid_d  = 1'b0;
    idle_inc = (idle_q == IDLE_TH) ? idle_q : idle_q + 1'b1;

    if (rx_if.x16_BAUD) begin
      unique case (state_q)
        INIT: begin
          if (rx) begin
            idle_d = idle_inc;
            if (idle_inc == IDLE_TH) state_d = IDLE;
          end else begin
            idle_d = '0;
          end
        end

        IDLE: begin
          if (!rx) begin
            state_d = START;
            tick_d  = '0;
          end
        end

        START: begin
          if (tick_q == tick_t'(MID_SAMPLE)) begin
            if (!rx) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = ERROR;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        DATA: begin
          if (tick_q == tick_t'(OVERSAMPLE - 1)) begin
            tick_d  = '0;
            shift_d = {rx, shift_q[DATA_BITS-1:1]};
            if (bit_q == bit_idx_t'(DATA_BITS - 1)) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        STOP: begin
          if (tick_q == tick_t'(OVERSAMPLE - 1)) begin
            tick_d = '0;
            if (rx) begin
              do_d    = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = ERROR;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        ERROR: begin
          state_d = ERROR;
        end

        default: begin
          state_d = ERROR;
        end
      endcase
    end
  end

  assign rx_if.Do    = do_q;
  assign rx_if.valid = valid_q;
  // error is a decode of the ERROR state; it holds until reset returns to INIT.
  assign rx_if.error = (state_q == ERROR);

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

  logic clk;
  logic rst;

  uart_rx_core_if bus ();

  uart_rx_core #(
    .P_REG_MODE_TH (160)
  ) dut (
    .CLK   (clk),
    .reset (rst),
    .rx_if (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  exp_q[$];

  logic [7:0] bytes_tbl [10] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01,
                                 8'h80, 8'hA5, 8'h3C, 8'h7E, 8'hC3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x tick: one CLK high every 9 CLKs
  initial begin
    bus.x16_BAUD = 1'b0;
    forever begin
      repeat (8) @(negedge clk);
      bus.x16_BAUD = 1'b1;
      @(negedge clk);
      bus.x16_BAUD = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ticks(input int unsigned n);
    repeat (n * 9) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_ok);
    if (expect_ok) exp_q.push_back(b);
    bus.serial_in = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      bus.serial_in = b[i];
      ticks(16);
    end
    bus.serial_in = stop_bit;
    ticks(16);
    bus.serial_in = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.serial_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every valid strobe pops the scoreboard and must last one CLK.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(bus.valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rx_byte", 32'(bus.Do), 32'(e));
        end
        @(negedge clk);
        check("valid_width", 32'(bus.valid), 32'd0);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.serial_in = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_do",    32'(bus.Do),    32'h00);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_error", 32'(bus.error), 32'd0);
    rst = 1'b0;

    // long idle -> regular mode, nothing reported
    ticks(200);
    check("idle_error", 32'(bus.error), 32'd0);

    // one-tick glitch is a false start
    bus.serial_in = 1'b0;
    ticks(1);
    bus.serial_in = 1'b1;
    ticks(16);
    check("glitch_error", 32'(bus.error), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_clears_error", 32'(bus.error), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // good byte, then a frame with a low stop bit
    ticks(200);
    send_frame(8'hA3, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0);
    check("stop_error", 32'(bus.error), 32'd1);
    check("stop_do_kept", 32'(bus.Do), 32'hA3);
    ticks(20);
    check("error_sticky", 32'(bus.error), 32'd1);

    // back-to-back frames
    do_reset();
    ticks(200);
    for (int i = 0; i < 10; i++) send_frame(bytes_tbl[i], 1'b1, 1'b1);
    ticks(4);
    check("b2b_error", 32'(bus.error), 32'd0);
    check("b2b_last_do", 32'(bus.Do), 32'hC3);

    // start bit before regular mode is ignored
    do_reset();
    ticks(50);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("early_error", 32'(bus.error), 32'd0);
    check("early_do", 32'(bus.Do), 32'h00);
    ticks(200);
    send_frame(8'h81, 1'b1, 1'b1);
    check("after_early_error", 32'(bus.error), 32'd0);

    // reset in the middle of a frame
    send_frame(8'h96, 1'b1, 1'b1);
    bus.serial_in = 1'b0;
    ticks(16);
    bus.serial_in = 1'b1;
    ticks(16);
    bus.serial_in = 1'b0;
    ticks(16);
    bus.serial_in = 1'b1;
    ticks(8);
    do_reset();
    check("midreset_do", 32'(bus.Do), 32'h00);
    check("midreset_error", 32'(bus.error), 32'd0);
    ticks(40);
    check("midreset_valid", 32'(bus.valid), 32'd0);
    check("midreset_do_late", 32'(bus.Do), 32'h00);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
